// File: rtl/mfp_uart_tx_if.sv
// Byte write port of the mfp_uart_tx transmitter: valid/ready handshake carrying one byte.
// The master drives data and valid; the transmitter answers with ready while its FIFO has room.
interface mfp_uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/mfp_uart_tx.sv
// Buffered 8N1 UART transmitter with a small byte FIFO and sticky overrun flag.
// Define MFP_UART_TX_PARITY_EN to add an even-parity bit (8E1, 11-bit frames).
module mfp_uart_tx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          SI_ClkIn,
    input  logic                          SI_Reset_N,
    mfp_uart_tx_if.slave                  wr,
    input  logic                          clr_overrun,
    output logic                          tx_overrun,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          UART_TX
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int BW  = $clog2(CPB);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef MFP_UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t         state_r;
    logic [BW-1:0]  baud_cnt_r;
    logic [2:0]     bit_idx_r;
    logic [7:0]     shift_r;
    logic           tx_r;
    logic [7:0]     mem_r [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic           overrun_r;
    logic           push_s;
    logic           pop_s;
    logic           baud_end_s;
    logic           fifo_empty_s;
    logic           fifo_full_s;

`ifdef MFP_UART_TX_PARITY_EN
    logic           parity_r;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    // FIFO status, handshake decode and the shifter-load (pop) condition
    always_comb begin
        fifo_empty_s = (count_r == CW'(0));
        fifo_full_s  = (count_r == CW'(FIFO_DEPTH));
        baud_end_s   = (baud_cnt_r == BW'(CPB - 1));
        push_s       = wr.tx_valid && !fifo_full_s;
        if (!fifo_empty_s && ((state_r == ST_IDLE) || ((state_r == ST_STOP) && baud_end_s))) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign wr.tx_ready = !fifo_full_s;
    assign tx_busy     = !fifo_empty_s || (state_r != ST_IDLE);
    assign fifo_count  = count_r;
    assign UART_TX     = tx_r;
    assign tx_overrun  = overrun_r;

    // Circular byte buffer; pointers wrap naturally because the depth is a power of two
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr.tx_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CW'(1);
            end else if (!push_s && pop_s) begin
                count_r <= count_r - CW'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Sticky overrun: a refused write wins over a same-cycle clear
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            overrun_r <= 1'b0;
        end else if (wr.tx_valid && fifo_full_s) begin
            overrun_r <= 1'b1;
        end else if (clr_overrun) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    // Frame sequencer: baud counter, bit shifter and the registered serial line
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= BW'(0);
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
`ifdef MFP_UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    baud_cnt_r <= BW'(0);
                    if (pop_s) begin
                        shift_r   <= mem_r[rd_ptr_r];
                        bit_idx_r <= 3'd0;
                        tx_r      <= 1'b0;
                        state_r   <= ST_START;
`ifdef MFP_UART_TX_PARITY_EN
                        parity_r  <= even_parity(mem_r[rd_ptr_r]);
`endif
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= BW'(0);
                        tx_r       <= shift_r[0];
                        state_r    <= ST_DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= BW'(0);
                        if (bit_idx_r == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
                            tx_r    <= parity_r;
                            state_r <= ST_PARITY;
`else
                            tx_r    <= 1'b1;
                            state_r <= ST_STOP;
`endif
                        end else begin
                            shift_r   <= shift_r >> 1;
                            tx_r      <= shift_r[1];
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BW'(1);
                    end
                end
`ifdef MFP_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= BW'(0);
                        tx_r       <= 1'b1;
                        state_r    <= ST_STOP;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= BW'(0);
                        // Queued byte goes straight into a new start bit, keeping frames contiguous
                        if (pop_s) begin
                            shift_r   <= mem_r[rd_ptr_r];
                            bit_idx_r <= 3'd0;
                            tx_r      <= 1'b0;
                            state_r   <= ST_START;
`ifdef MFP_UART_TX_PARITY_EN
                            parity_r  <= even_parity(mem_r[rd_ptr_r]);
`endif
                        end else begin
                            tx_r    <= 1'b1;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BW'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    baud_cnt_r <= BW'(0);
                    tx_r       <= 1'b1;
                end
            endcase
        end
    end
endmodule
